// File: rtl/usb_port_arbiter.sv
// usb_port_arbiter
//   Round-robin arbiter that lets NUM_PORTS downstream requesters share one
//   upstream transmit stream, one whole packet at a time.
//   Optional build macro: USB_ARB_TIMEOUT_EN enables the stall watchdog
//   (grant revoked with an abort pulse after TIMEOUT_CYCLES beat-less cycles).
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   port_req             per-port packet request
//   port_data            per-port beat data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   port_val, port_last  per-port beat valid / final beat of packet
//   port_ready           beat accept, driven only toward the granted port
//   grant                registered one-hot grant
//   out_data/val/last    muxed stream toward the upstream transmitter
//   out_ready            upstream accept
//   busy                 high whenever the arbiter is not idle
//   abort                one-cycle pulse when a grant is revoked by timeout
//   beat_count           beats accepted in the current packet, saturating
module usb_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
  input  logic [NUM_PORTS-1:0]            port_val,
  input  logic [NUM_PORTS-1:0]            port_last,
  output logic [NUM_PORTS-1:0]            port_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_val,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            abort,
  output logic [15:0]                     beat_count
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [3:0]         gap_cnt;

  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_PORTS-1:0] pick_oh;
  logic               found;
  logic               beat;

`ifdef USB_ARB_TIMEOUT_EN
  logic [15:0]        stall_cnt;
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  // Search starts one past the previous winner and wraps, so the previous
  // winner is considered last.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand_idx = IDX_W'((32'(last_grant) + k) % NUM_PORTS);
      if (!found && port_req[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
    pick_oh[pick_idx] = found;
  end

  // Stream mux: only the granted port is visible, and only while in XFER.
  always_comb begin
    out_data   = '0;
    out_val    = 1'b0;
    out_last   = 1'b0;
    port_ready = '0;
    if (state == XFER) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (grant[i]) begin
          out_data      = port_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_val       = port_val[i];
          out_last      = port_last[i];
          port_ready[i] = out_ready;
        end
      end
    end
  end

  assign beat = (state == XFER) && out_val && out_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      gap_cnt    <= '0;
      abort      <= 1'b0;
      beat_count <= '0;
`ifdef USB_ARB_TIMEOUT_EN
      stall_cnt  <= '0;
`endif
    end else begin
      abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant      <= pick_oh;
            last_grant <= pick_idx;
            beat_count <= '0;
`ifdef USB_ARB_TIMEOUT_EN
            stall_cnt  <= '0;
`endif
            state      <= XFER;
          end else begin
            grant <= '0;
          end
        end

        XFER: begin
          if (beat) begin
            if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
`ifdef USB_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (out_last) begin
              state   <= GAP;
              grant   <= '0;
              gap_cnt <= '0;
            end
          end
`ifdef USB_ARB_TIMEOUT_EN
          // This cycle is the TIMEOUT_CYCLES-th stall: revoke the grant.
          else if (stall_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            stall_cnt <= stall_cnt + 16'd1;
            abort     <= 1'b1;
            state     <= GAP;
            grant     <= '0;
            gap_cnt   <= '0;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
`endif
        end

        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
